alu_mul_seq: RTL
================

ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand width; only 32 is supported, because the shared ALU is 32-bit.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  input  1  request a multiply; sampled only in IDLE.
REQ-005 SHALL have port: flush  input  1  synchronous abort; has priority over start.
REQ-006 SHALL have port: op_a  input  32  multiplicand (unsigned), captured on accepted start.
REQ-007 SHALL have port: op_b  input  32  multiplier (unsigned), captured on accepted start.
REQ-008 SHALL have port: busy  output  1  high in RUN.
REQ-009 SHALL have port: done  output  1  one-cycle pulse, high in DONE.
REQ-010 SHALL have port: prod_hi  output  32  upper half of the 64-bit product.
REQ-011 SHALL have port: prod_lo  output  32  lower half of the 64-bit product.
REQ-012 SHALL have port: alu_ct  output  4  ALU control code driven to the shared ALU.
REQ-013 SHALL have port: alu_src1  output  32  ALU operand 1.
REQ-014 SHALL have port: alu_src2  output  32  ALU operand 2.
REQ-015 SHALL have port: alu_res  input  32  ALU result, combinational, same cycle.

Function
REQ-016 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-017 SHALL transition IDLE->RUN on the edge where start=1 and flush=0.
- On that edge: acc<=0, lo<=op_b, mcand<=op_a, cnt<=0.
REQ-018 SHALL perform exactly one shift-add iteration on every RUN cycle.
- alu_ct=4'b0010 (add), alu_src1=acc.
- alu_src2=mcand if lo[0]=1, else 0.
REQ-019 SHALL compute carry as (alu_res < acc) unsigned, and update on each RUN edge:
- {acc, lo} <= {carry, alu_res, lo[31:1]} (a 65-bit value shifted right by 1).
- cnt <= cnt+1.
REQ-020 SHALL move RUN->DONE on the edge where cnt==31, i.e. after 32 iterations.
REQ-021 SHALL, in DONE: assert done=1 for exactly one cycle, then go DONE->IDLE unconditionally.
- start in DONE is ignored.
REQ-022 SHALL drive prod_hi=acc and prod_lo=lo in all states.
- The values are valid from the DONE cycle and held until the next accepted start, flush or reset.
REQ-023 SHALL have a fixed latency: start sampled at edge E0, done high between E32 and E33, back in IDLE at E33.
- Independent of operand values, including zero operands.
REQ-024 SHALL ignore start while in RUN; operands are not re-captured and the run is not disturbed.
REQ-025 SHALL, when flush=1 in any state: go to IDLE on the next edge, clear acc, lo and cnt to 0, and suppress done.
REQ-026 SHALL drive alu_ct=4'b0000, alu_src1=0 and alu_src2=0 whenever the state is not RUN, so the ALU output is 0.
REQ-027 SHALL produce a product equal to op_a*op_b mod 2^64 for all 32-bit unsigned operands.
REQ-028 SHALL decode busy and done from the state register only, with no combinational path from start to them.

Reset
REQ-029 SHALL, while rst=0, asynchronously force: state=IDLE, acc=0, lo=0, mcand=0, cnt=0.
- Outputs then read busy=0, done=0, prod_hi=0, prod_lo=0, alu_ct=0, alu_src1=0, alu_src2=0.
REQ-030 SHALL abandon any run in progress when reset is asserted mid-RUN; no done is produced for it.
REQ-031 SHALL start in IDLE after reset release and ignore start until the first rising edge following release.

Structure
REQ-032 SHALL take ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_NOP=4'b0000, WIDTH=32 and the state encoding (IDLE, RUN, DONE) from the shared package alu_pkg.
REQ-033 SHALL be a single module with no sub-module; the shared ALU is instantiated by the parent and connected through alu_ct, alu_src1, alu_src2 and alu_res.
REQ-034 SHALL use a 5-bit iteration counter and 32-bit registers acc, lo and mcand.

Verification
REQ-035 SHALL pass basic: op_a=3, op_b=5, start for 1 cycle -> done at E32, prod_hi=0, prod_lo=15, busy high for 32 cycles.
REQ-036 SHALL pass carry: op_a=op_b=0xFFFFFFFF -> prod_hi=0xFFFFFFFE, prod_lo=0x00000001.
REQ-037 SHALL pass zero/mixed operands: op_a=0, op_b=0x12345678 -> product 0, done still at E32; op_a=0x10000, op_b=0x10000 -> prod_hi=1, prod_lo=0.
REQ-038 SHALL pass start while busy: start pulsed again at iteration 10 with op_a=7 -> ignored, first product unchanged, single done pulse.
REQ-039 SHALL pass flush: flush at iteration 10 -> IDLE next edge, prod=0, no done; a new start then completes normally.
REQ-040 SHALL pass reset mid-run: rst=0 at iteration 20, asynchronous -> all outputs 0 immediately; after release, 6*7 gives prod_lo=42.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, datapath width and the multiplier state encoding.
// Pure constants and types; no timing or flow control of its own.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [3:0] ALU_NOP = 4'b0000;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned 32x32->64 shift-add multiplier that borrows the shared ALU; done pulses 32 cycles after start.
// No backpressure: start is taken only in IDLE, flush aborts from any state.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic [3:0]       alu_ct,
    output logic [WIDTH-1:0] alu_src1,
    output logic [WIDTH-1:0] alu_src2,
    input  logic [WIDTH-1:0] alu_res
);

    mul_state_e       state_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] mcand_q;
    logic [4:0]       cnt_q;

    logic             carry;
    logic [WIDTH-1:0] acc_d;
    logic [WIDTH-1:0] lo_d;

    // ALU inputs are gated to zero outside RUN so the shared ALU idles at 0.
    always_comb begin
        alu_ct   = ALU_NOP;
        alu_src1 = '0;
        alu_src2 = '0;
        if (state_q == RUN) begin
            alu_ct   = ALU_ADD;
            alu_src1 = acc_q;
            alu_src2 = lo_q[0] ? mcand_q : '0;
        end
    end

    // An unsigned add wrapped iff its result is below an operand; this is bit 64 of the partial sum.
    assign carry          = (alu_res < acc_q);
    assign {acc_d, lo_d}  = {carry, alu_res, lo_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            acc_q   <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= RUN;
                        acc_q   <= '0;
                        lo_q    <= op_b;
                        mcand_q <= op_a;
                        cnt_q   <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_d;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'(WIDTH - 1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign prod_hi = acc_q;
    assign prod_lo = lo_q;

endmodule
